// File: rtl/beverage_vend_ctrl.sv
// Vending core: coin credit, one-hot drink select, price check, change, timed ingredient sequence.
// Latency: start condition at cycle t -> busy and first ingredient valve at t+1; disp lags credit/change by one cycle.
// Backpressure: none; coins that cannot be taken (overflow, cancel/start same cycle, not idle) pulse o_coin_reject.
//
// Ports:
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   i_coin_lo, i_coin_hi    single-cycle coin pulses worth COIN_LO / COIN_HI
//   i_cancel                level, refunds the accumulated credit while idle
//   i_drink_sel             debounced switches, exactly one high selects a drink
//   o_credit, o_change      accumulated credit, last change/refund (held)
//   o_change_valid          pulse when o_change is written
//   o_coin_reject           pulse when a coin is refused
//   o_ingredient, o_busy    active valve (one-hot or zero), high while dispensing
//   o_done                  pulse at the end of a drink
//   o_disp                  change if non-zero, otherwise credit (registered)
module beverage_vend_ctrl #(
  parameter int N_DRINKS = 4,
  parameter int N_ING    = 5,
  parameter int CREDIT_W = 4,
  parameter int COIN_LO  = 1,
  parameter int COIN_HI  = 5,
  parameter logic [N_DRINKS*CREDIT_W-1:0] PRICES    = {4'd8, 4'd7, 4'd6, 4'd4},
  parameter logic [N_DRINKS*N_ING-1:0]    RECIPES   = {5'h1F, 5'h0B, 5'h03, 5'h01},
  parameter logic [N_ING*8-1:0]           ING_TICKS = {N_ING{8'd2}},
  parameter int TICK_DIV = 100_000_000
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_coin_lo,
  input  logic                i_coin_hi,
  input  logic                i_cancel,
  input  logic [N_DRINKS-1:0] i_drink_sel,
  output logic [CREDIT_W-1:0] o_credit,
  output logic [CREDIT_W-1:0] o_change,
  output logic                o_change_valid,
  output logic                o_coin_reject,
  output logic [N_ING-1:0]    o_ingredient,
  output logic                o_busy,
  output logic                o_done,
  output logic [CREDIT_W-1:0] o_disp
);

  localparam int MAX_CREDIT = (1 << CREDIT_W) - 1;
  localparam int PRE_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W      = (N_ING > 1) ? $clog2(N_ING) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DISPENSE, S_DONE} state_t;

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] r_change;
  logic                r_change_vld;
  logic                r_reject;
  logic [N_ING-1:0]    r_ing;
  logic [N_ING-1:0]    r_mask;
  logic [IDX_W-1:0]    r_idx;
  logic                r_busy;
  logic                r_done;
  logic [CREDIT_W-1:0] r_disp;
  logic [PRE_W-1:0]    r_pre;
  logic [7:0]          r_tick;

  logic [CREDIT_W-1:0] w_price;
  logic [N_ING-1:0]    w_recipe;
  logic                w_start;
  logic                w_first_vld;
  logic [IDX_W-1:0]    w_first_idx;
  logic                w_next_vld;
  logic [IDX_W-1:0]    w_next_idx;
  logic [7:0]          w_ticks;
  logic [7:0]          w_tick_end;
  logic                w_pre_end;
  logic                w_any_coin;
  logic [CREDIT_W:0]   w_coin_val;
  logic [CREDIT_W:0]   w_sum;
  logic                w_coin_ok;

  // Drink decode: price/recipe of the single raised switch.
  always_comb begin
    w_price  = '0;
    w_recipe = '0;
    for (int k = 0; k < N_DRINKS; k++) begin
      if (i_drink_sel[k]) begin
        w_price  = PRICES[k*CREDIT_W +: CREDIT_W];
        w_recipe = RECIPES[k*N_ING +: N_ING];
      end
    end
    w_start = $onehot(i_drink_sel) && (r_credit >= w_price);
  end

  // Lowest set bit of the new recipe, and lowest set bit above the current valve.
  // Descending loops so the lowest match is the last assignment.
  always_comb begin
    w_first_vld = 1'b0;
    w_first_idx = '0;
    w_next_vld  = 1'b0;
    w_next_idx  = '0;
    for (int j = N_ING - 1; j >= 0; j--) begin
      if (w_recipe[j]) begin
        w_first_vld = 1'b1;
        w_first_idx = IDX_W'(j);
      end
      if (r_mask[j] && (j > int'(r_idx))) begin
        w_next_vld = 1'b1;
        w_next_idx = IDX_W'(j);
      end
    end
  end

  // Tick budget of the active valve; a zero entry behaves as one tick.
  always_comb begin
    w_ticks = 8'd1;
    for (int j = 0; j < N_ING; j++) begin
      if (j == int'(r_idx)) w_ticks = ING_TICKS[j*8 +: 8];
    end
    w_tick_end = (w_ticks == 8'd0) ? 8'd0 : w_ticks - 8'd1;
    w_pre_end  = (r_pre == PRE_W'(TICK_DIV - 1));
  end

  // Coin sum is one bit wider than credit so overflow is visible.
  always_comb begin
    w_any_coin = i_coin_lo | i_coin_hi;
    w_coin_val = (i_coin_lo ? (CREDIT_W+1)'(COIN_LO) : '0) +
                 (i_coin_hi ? (CREDIT_W+1)'(COIN_HI) : '0);
    w_sum      = {1'b0, r_credit} + w_coin_val;
    w_coin_ok  = (w_sum <= (CREDIT_W+1)'(MAX_CREDIT));
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_credit     <= '0;
      r_change     <= '0;
      r_change_vld <= 1'b0;
      r_reject     <= 1'b0;
      r_ing        <= '0;
      r_mask       <= '0;
      r_idx        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_disp       <= '0;
      r_pre        <= '0;
      r_tick       <= '0;
    end else begin
      r_change_vld <= 1'b0;
      r_reject     <= 1'b0;
      r_done       <= 1'b0;
      r_disp       <= (r_change != '0) ? r_change : r_credit;
      case (r_state)
        S_IDLE: begin
          if (i_cancel) begin
            r_change     <= r_credit;
            r_credit     <= '0;
            r_change_vld <= 1'b1;
            r_reject     <= w_any_coin;
          end else if (w_start) begin
            r_change     <= r_credit - w_price;
            r_credit     <= '0;
            r_change_vld <= 1'b1;
            r_reject     <= w_any_coin;
            r_mask       <= w_recipe;
            r_idx        <= w_first_idx;
            r_ing        <= w_first_vld ? (N_ING'(1) << w_first_idx) : '0;
            r_pre        <= '0;
            r_tick       <= '0;
            r_busy       <= 1'b1;
            r_state      <= S_DISPENSE;
          end else if (w_any_coin) begin
            if (w_coin_ok) begin
              r_credit <= w_sum[CREDIT_W-1:0];
              r_change <= '0;
            end else begin
              r_reject <= 1'b1;
            end
          end
        end
        S_DISPENSE: begin
          r_reject <= w_any_coin;
          if (r_ing == '0) begin
            // Empty recipe: one idle dispense cycle, then finish.
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_pre_end) begin
            r_pre <= '0;
            if (r_tick == w_tick_end) begin
              r_tick <= '0;
              if (w_next_vld) begin
                r_idx <= w_next_idx;
                r_ing <= N_ING'(1) << w_next_idx;
              end else begin
                r_ing   <= '0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end
            end else begin
              r_tick <= r_tick + 8'd1;
            end
          end else begin
            r_pre <= r_pre + PRE_W'(1);
          end
        end
        S_DONE: begin
          r_reject <= w_any_coin;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_credit       = r_credit;
  assign o_change       = r_change;
  assign o_change_valid = r_change_vld;
  assign o_coin_reject  = r_reject;
  assign o_ingredient   = r_ing;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_disp         = r_disp;

endmodule
